// File: rtl/fifo_param_if.sv
// Write/read handshake and status bundle for fifo_param; master drives requests, slave is the FIFO.
// Status and data returned on the same bundle; count is sized to hold 0..FIFO_DEPTH.
interface fifo_param_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO, any depth >= 2; data_out/status pulses one cycle after the deciding edge, flags combinational.
// Writes rejected when full (overflow pulse), reads rejected when empty (underflow pulse); no internal stall.
module fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_param_if.slave  fifo_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_c, empty_c;
  logic wr_acc, rd_acc;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    full_c  = (count_q == CNT_FULL);
    empty_c = (count_q == '0);
    wr_acc  = fifo_if.wr_en && !full_c;
    rd_acc  = fifo_if.rd_en && !empty_c;

    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    data_out_d  = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    rd_valid_d  = rd_acc;
    wr_ack_d    = wr_acc;
    overflow_d  = fifo_if.wr_en && full_c;
    underflow_d = fifo_if.rd_en && empty_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately unreset; empty gating keeps stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= fifo_if.data_in;
    end
  end

  assign fifo_if.data_out    = data_out_q;
  assign fifo_if.rd_valid    = rd_valid_q;
  assign fifo_if.wr_ack      = wr_ack_q;
  assign fifo_if.overflow    = overflow_q;
  assign fifo_if.underflow   = underflow_q;
  assign fifo_if.count       = count_q;
  assign fifo_if.full        = full_c;
  assign fifo_if.empty       = empty_c;
  assign fifo_if.almostfull  = (count_q >= CNT_AF) && !full_c;
  assign fifo_if.almostempty = (count_q <= CNT_AE) && !empty_c;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_FULL);
  a_ptr_bound:   assert property (@(posedge clk) disable iff (!rst_n)
                                  (wr_ptr_q <= PTR_LAST) && (rd_ptr_q <= PTR_LAST));

endmodule
